// File: rtl/leaf_out_port_arbiter_pkg.sv
// leaf_out_port_arbiter_pkg: shared width defaults, arbitration modes and a
// compile-time log2 helper for the leaf output arbiter.
package leaf_out_port_arbiter_pkg;
   localparam int PAYLOAD_BITS_DEF = 32;
   localparam int PORT_BITS_DEF = 4;
   typedef enum int {ARB_RR = 0, ARB_FIXED = 1} arb_mode_e;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/leaf_out_port_arbiter_if.sv
// leaf_out_port_arbiter_if: kernel-side channels and merged leaf-interface stream.
interface leaf_out_port_arbiter_if
   import leaf_out_port_arbiter_pkg::*;
#(
   parameter int PAYLOAD_BITS = PAYLOAD_BITS_DEF,
   parameter int NUM_CH = 4,
   parameter int PORT_BITS = PORT_BITS_DEF,
   parameter int FIFO_DEPTH = 8
);
   localparam int CNT_BITS = clog2(FIFO_DEPTH) + 1;
   logic [NUM_CH*PAYLOAD_BITS-1:0] din_user;
   logic [NUM_CH-1:0] vld_user;
   logic [NUM_CH-1:0] ack_user;
   logic [PAYLOAD_BITS-1:0] dout_intf;
   logic [PORT_BITS-1:0] port_intf;
   logic vld_intf;
   logic ack_intf;
   logic [NUM_CH*CNT_BITS-1:0] occupancy;
   modport master (
      input din_user, vld_user, ack_intf,
      output ack_user, dout_intf, port_intf, vld_intf, occupancy
   );
   modport slave (
      output din_user, vld_user, ack_intf,
      input ack_user, dout_intf, port_intf, vld_intf, occupancy
   );
endinterface

// File: rtl/leaf_out_port_arbiter_chan_fifo.sv
// leaf_out_port_arbiter_chan_fifo: per-channel synchronous FIFO; ack is a
// registered not-full so the kernel never sees a combinational path.
module leaf_out_port_arbiter_chan_fifo
   import leaf_out_port_arbiter_pkg::*;
#(
   parameter int PAYLOAD_BITS = PAYLOAD_BITS_DEF,
   parameter int FIFO_DEPTH = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic vld_i,
   input  logic pop_i,
   input  logic [PAYLOAD_BITS-1:0] data_i,
   output logic [PAYLOAD_BITS-1:0] data_o,
   output logic ack_o,
   output logic empty_o,
   output logic [clog2(FIFO_DEPTH):0] count_o
);
   localparam int AW = clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [CW-1:0] count_q, count_d;
   logic ack_q, empty_q, push;
   assign push = vld_i && ack_q;
   assign count_d = count_q + CW'(push) - CW'(pop_i);
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wp_q <= '0;
         rp_q <= '0;
         count_q <= '0;
         ack_q <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         wp_q <= wp_q + AW'(push);
         rp_q <= rp_q + AW'(pop_i);
         count_q <= count_d;
         ack_q <= count_d != CW'(FIFO_DEPTH);
         empty_q <= count_d == '0;
      end
   end
   always_ff @(posedge clk_i) if (push) mem_q[wp_q] <= data_i;
   assign data_o = mem_q[rp_q];
   assign ack_o = ack_q;
   assign empty_o = empty_q;
   assign count_o = count_q;
   a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i) !(pop_i && empty_q));
   a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push && count_q == CW'(FIFO_DEPTH)));
endmodule

// File: rtl/leaf_out_port_arbiter.sv
// leaf_out_port_arbiter: merges NUM_CH buffered kernel streams into one tagged
// leaf-interface stream through a single output register.
module leaf_out_port_arbiter
   import leaf_out_port_arbiter_pkg::*;
#(
   parameter int PAYLOAD_BITS = PAYLOAD_BITS_DEF,
   parameter int NUM_CH = 4,
   parameter int PORT_BITS = PORT_BITS_DEF,
   parameter int FIFO_DEPTH = 8,
   parameter arb_mode_e ARB_MODE = ARB_RR
) (
   input logic clk_user,
   input logic reset,
   leaf_out_port_arbiter_if.master bus
);
   localparam int CW = clog2(FIFO_DEPTH) + 1;
   logic [PAYLOAD_BITS-1:0] head [NUM_CH];
   logic [NUM_CH-1:0] empty, pop, ack;
   logic [NUM_CH*CW-1:0] occ;
   logic [PORT_BITS-1:0] last_q, port_q, gnt;
   logic [PAYLOAD_BITS-1:0] dout_q, data_d;
   logic vld_q, any, load;
   int base;
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      leaf_out_port_arbiter_chan_fifo #(.PAYLOAD_BITS(PAYLOAD_BITS), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
         .clk_i(clk_user),
         .rst_i(reset),
         .vld_i(bus.vld_user[i]),
         .pop_i(pop[i]),
         .data_i(bus.din_user[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
         .data_o(head[i]),
         .ack_o(ack[i]),
         .empty_o(empty[i]),
         .count_o(occ[i*CW +: CW])
      );
      assign pop[i] = load && any && gnt == PORT_BITS'(i);
   end
   assign load = !vld_q || bus.ack_intf;
   // Visit channels in priority order starting at base; first non-empty wins.
   always_comb begin
      base = ARB_MODE == ARB_FIXED ? 0 : int'(last_q) + 1;
      any = 1'b0;
      gnt = '0;
      data_d = '0;
      for (int k = 0; k < NUM_CH; k++)
         for (int j = 0; j < NUM_CH; j++)
            if (!any && !empty[j] && j == (base + k) % NUM_CH) begin
               any = 1'b1;
               gnt = PORT_BITS'(j);
               data_d = head[j];
            end
   end
   always_ff @(posedge clk_user) begin
      if (reset) begin
         vld_q <= 1'b0;
         dout_q <= '0;
         port_q <= '0;
         last_q <= PORT_BITS'(NUM_CH - 1);
      end else if (load) begin
         vld_q <= any;
         dout_q <= any ? data_d : dout_q;
         port_q <= any ? gnt : port_q;
         last_q <= any ? gnt : last_q;
      end
   end
   assign bus.ack_user = ack;
   assign bus.occupancy = occ;
   assign bus.dout_intf = dout_q;
   assign bus.port_intf = port_q;
   assign bus.vld_intf = vld_q;
endmodule

// File: tb/tb_leaf_out_port_arbiter.sv
// tb_leaf_out_port_arbiter: round-robin and fixed-priority instances share one
// stimulus stream and are checked every cycle against queue-based models.
module tb_leaf_out_port_arbiter;
   import leaf_out_port_arbiter_pkg::*;
   localparam int NCH = 4, PB = 32, PTB = 4, DEPTH = 8, CW = 4;
   logic clk = 1'b0, reset = 1'b1, ack_intf = 1'b0;
   logic [NCH*PB-1:0] din = '0;
   logic [NCH-1:0] vld = '0;
   always #5 clk = ~clk;
   leaf_out_port_arbiter_if #(.PAYLOAD_BITS(PB), .NUM_CH(NCH), .PORT_BITS(PTB), .FIFO_DEPTH(DEPTH)) bus_rr ();
   leaf_out_port_arbiter_if #(.PAYLOAD_BITS(PB), .NUM_CH(NCH), .PORT_BITS(PTB), .FIFO_DEPTH(DEPTH)) bus_fx ();
   assign bus_rr.din_user = din;
   assign bus_rr.vld_user = vld;
   assign bus_rr.ack_intf = ack_intf;
   assign bus_fx.din_user = din;
   assign bus_fx.vld_user = vld;
   assign bus_fx.ack_intf = ack_intf;
   leaf_out_port_arbiter #(.PAYLOAD_BITS(PB), .NUM_CH(NCH), .PORT_BITS(PTB), .FIFO_DEPTH(DEPTH), .ARB_MODE(ARB_RR)) u_rr (
      .clk_user(clk), .reset(reset), .bus(bus_rr));
   leaf_out_port_arbiter #(.PAYLOAD_BITS(PB), .NUM_CH(NCH), .PORT_BITS(PTB), .FIFO_DEPTH(DEPTH), .ARB_MODE(ARB_FIXED)) u_fx (
      .clk_user(clk), .reset(reset), .bus(bus_fx));

   // Model index 0 = round-robin instance, 1 = fixed-priority instance.
   logic [PB-1:0] q [2][NCH][$];
   logic m_vld [2];
   logic [PB-1:0] m_dout [2];
   int m_port [2], m_last [2];
   logic [NCH-1:0] m_ack [2];
   bit started = 1'b0;
   int n_chk = 0, n_fail = 0;

   task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      int pick, c;
      if (reset) started = 1'b1;
      for (int m = 0; m < 2; m++) begin
         if (reset) begin
            for (int j = 0; j < NCH; j++) q[m][j].delete();
            m_vld[m] = 1'b0;
            m_last[m] = NCH - 1;
            m_ack[m] = '0;
         end else begin
            if (!m_vld[m] || ack_intf) begin
               pick = -1;
               for (int k = 0; k < NCH; k++) begin
                  c = m == 0 ? (m_last[m] + 1 + k) % NCH : k;
                  if (pick < 0 && q[m][c].size() > 0) pick = c;
               end
               m_vld[m] = pick >= 0;
               if (pick >= 0) begin
                  m_dout[m] = q[m][pick].pop_front();
                  m_port[m] = pick;
                  m_last[m] = pick;
               end
            end
            for (int j = 0; j < NCH; j++) if (vld[j] && m_ack[m][j]) q[m][j].push_back(din[j*PB +: PB]);
            for (int j = 0; j < NCH; j++) m_ack[m][j] = q[m][j].size() < DEPTH;
         end
      end
   end

   task automatic cmp_dut(input int m, input logic v, input logic [PB-1:0] d, input logic [PTB-1:0] p,
                          input logic [NCH-1:0] a, input logic [NCH*CW-1:0] occ);
      chk($sformatf("m%0d vld_intf", m), v, m_vld[m]);
      if (m_vld[m]) begin
         chk($sformatf("m%0d dout_intf", m), d, m_dout[m]);
         chk($sformatf("m%0d port_intf", m), p, m_port[m]);
      end
      chk($sformatf("m%0d ack_user", m), a, m_ack[m]);
      for (int j = 0; j < NCH; j++) chk($sformatf("m%0d occupancy[%0d]", m, j), occ[j*CW +: CW], q[m][j].size());
   endtask

   always @(negedge clk) if (started) begin
      cmp_dut(0, bus_rr.vld_intf, bus_rr.dout_intf, bus_rr.port_intf, bus_rr.ack_user, bus_rr.occupancy);
      cmp_dut(1, bus_fx.vld_intf, bus_fx.dout_intf, bus_fx.port_intf, bus_fx.ack_user, bus_fx.occupancy);
   end

   task automatic pulse_reset();
      reset = 1'b1;
      vld = '0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic rand_din();
      din = {$urandom, $urandom, $urandom, $urandom};
   endtask

   initial begin
      vld = '1;
      rand_din();
      repeat (3) @(negedge clk);
      chk("reset vld_intf", bus_rr.vld_intf, 0);
      chk("reset dout_intf", bus_rr.dout_intf, 0);
      chk("reset port_intf", bus_rr.port_intf, 0);
      chk("reset occupancy", bus_rr.occupancy, 0);
      chk("reset ack_user", bus_rr.ack_user, 0);
      chk("reset fx ack_user", bus_fx.ack_user, 0);
      reset = 1'b0;
      vld = '0;
      @(negedge clk);
      chk("release ack_user", bus_rr.ack_user, 4'hF);
      // single word on ch2
      ack_intf = 1'b1;
      vld = 4'b0100;
      din[2*PB +: PB] = 32'hA5A5_0001;
      @(negedge clk);
      vld = '0;
      @(negedge clk);
      chk("single vld", bus_rr.vld_intf, 1);
      chk("single dout", bus_rr.dout_intf, 32'hA5A5_0001);
      chk("single port", bus_rr.port_intf, 2);
      @(negedge clk);
      chk("single one cycle", bus_rr.vld_intf, 0);
      // all channels saturated
      pulse_reset();
      vld = '1;
      rand_din();
      @(negedge clk);
      for (int k = 0; k < 12; k++) begin
         rand_din();
         @(negedge clk);
         chk("rr seq vld", bus_rr.vld_intf, 1);
         chk("rr seq port", bus_rr.port_intf, k % 4);
         chk("fx seq port", bus_fx.port_intf, 0);
      end
      // fill ch1 with the output stalled
      pulse_reset();
      ack_intf = 1'b0;
      for (int k = 0; k < 9; k++) begin
         vld = 4'b0010;
         din[PB +: PB] = 32'h100 + k;
         @(negedge clk);
      end
      vld = '0;
      for (int k = 0; k < 3; k++) begin
         chk("full occupancy[1]", bus_rr.occupancy[CW +: CW], 8);
         chk("full ack_user[1]", bus_rr.ack_user[1], 0);
         chk("stall vld", bus_rr.vld_intf, 1);
         chk("stall dout", bus_rr.dout_intf, 32'h100);
         @(negedge clk);
      end
      ack_intf = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         chk("drain dout", bus_rr.dout_intf, 32'h100 + k);
      end
      chk("drain ack_user[1]", bus_rr.ack_user[1], 1);
      @(negedge clk);
      chk("drain done", bus_rr.vld_intf, 0);
      // fixed priority: ch0 before ch3
      pulse_reset();
      for (int k = 0; k < 10; k++) begin
         vld = k < 4 ? 4'b1001 : 4'b0000;
         din[0 +: PB] = 32'h500 + k;
         din[3*PB +: PB] = 32'h530 + k;
         @(negedge clk);
         if (k >= 1 && k <= 8) begin
            chk("fx prio vld", bus_fx.vld_intf, 1);
            chk("fx prio port", bus_fx.port_intf, k <= 4 ? 0 : 3);
         end
      end
      // reset while stalled with buffered words
      pulse_reset();
      ack_intf = 1'b0;
      for (int k = 0; k < 3; k++) begin
         vld = '1;
         rand_din();
         @(negedge clk);
      end
      vld = '0;
      chk("pre-reset vld", bus_rr.vld_intf, 1);
      chk("pre-reset occupancy", bus_rr.occupancy, 16'h3332);
      chk("pre-reset fx occupancy", bus_fx.occupancy, 16'h3332);
      reset = 1'b1;
      @(negedge clk);
      chk("mid reset vld", bus_rr.vld_intf, 0);
      chk("mid reset occupancy", bus_rr.occupancy, 0);
      chk("mid reset fx vld", bus_fx.vld_intf, 0);
      reset = 1'b0;
      ack_intf = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("no stale word", bus_rr.vld_intf | bus_fx.vld_intf, 0);
      end
      // randomized traffic with occasional resets
      for (int k = 0; k < 3000; k++) begin
         vld = NCH'($urandom);
         rand_din();
         ack_intf = $urandom_range(0, 3) != 0;
         reset = $urandom_range(0, 299) == 0;
         @(negedge clk);
      end
      reset = 1'b0;
      vld = '0;
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
